// File: rtl/aes_uart_pkg.sv
// Shared types and sizes for the UART-to-AES plaintext path.
package aes_uart_pkg;
  localparam int unsigned BLOCK_BYTES_DEF = 16;
  localparam int unsigned BLOCK_W         = 128;

  typedef enum logic {FILL, WAIT} packer_state_t;
  typedef logic [BLOCK_W-1:0] block_t;
endpackage

// File: rtl/uart_block_packer_if.sv
// Block handshake between the packer (master) and the AES core (slave).
interface uart_block_packer_if
  import aes_uart_pkg::*;
#(
  parameter int unsigned W = BLOCK_W
);
  logic [W-1:0] block_data;
  logic         block_valid;
  logic         block_ready;

  modport master (output block_data, output block_valid, input block_ready);
  modport slave  (input block_data, input block_valid, output block_ready);
endinterface

// File: rtl/uart_idle_timer.sv
// Idle-clock counter; expire pulses for one cycle on the TIMEOUT_CYCLES-th enabled clock. 0 disables it.
module uart_idle_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);
  generate
    if (TIMEOUT_CYCLES == 0) begin : g_off
      logic w_unused;
      assign w_unused = &{1'b0, clk, rst, clr, en};
      assign expire   = 1'b0;
    end else begin : g_on
      localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
      logic [CW-1:0] r_cnt;
      logic          w_at_limit;

      assign w_at_limit = (r_cnt == CW'(TIMEOUT_CYCLES - 1));
      assign expire     = en & ~clr & w_at_limit;

      always_ff @(posedge clk) begin
        if (rst || clr) begin
          r_cnt <= '0;
        end else if (en) begin
          r_cnt <= w_at_limit ? '0 : r_cnt + 1'b1;
        end
      end
    end
  endgenerate
endmodule

// File: rtl/uart_block_packer.sv
// Packs UART bytes (first byte at MSB) into blocks for the AES core.
// Define UART_BLOCK_PAD_EN to emit zero-padded partial blocks on timeout instead of dropping them.
module uart_block_packer
  import aes_uart_pkg::*;
#(
  parameter int unsigned BLOCK_BYTES    = BLOCK_BYTES_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [7:0]                   rx_data,
  input  logic                         rx_valid,
  input  logic                         rx_err,
  uart_block_packer_if.master          blk,
  output logic [$clog2(BLOCK_BYTES):0] byte_cnt,
  output logic                         overflow,
  output logic                         drop_pulse
);
  localparam int unsigned W  = BLOCK_BYTES * 8;
  localparam int unsigned CW = $clog2(BLOCK_BYTES) + 1;

  packer_state_t r_state;
  logic [W-1:0]  r_asm;
  logic [W-1:0]  r_hold;
  logic          r_valid;
  logic [CW-1:0] r_cnt;
  logic          r_ovf;
  logic          r_drop;

  logic [W-1:0]  w_shifted;
  logic          w_last;
  logic          w_hold_free;
  logic          w_timer_en;
  logic          w_expire;

  assign w_shifted   = {r_asm[W-9:0], rx_data};
  assign w_last      = (r_cnt == CW'(BLOCK_BYTES - 1));
  assign w_hold_free = ~r_valid | blk.block_ready;
  assign w_timer_en  = (r_state == FILL) && (r_cnt != '0);

`ifdef UART_BLOCK_PAD_EN
  localparam int unsigned SW = $clog2(W) + 1;
  logic [SW-1:0] w_shamt;
  logic [W-1:0]  w_padded;
  assign w_shamt  = SW'((BLOCK_BYTES - int'(r_cnt)) * 8);
  assign w_padded = r_asm << w_shamt;
`endif

  uart_idle_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_idle_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (rx_valid),
    .en     (w_timer_en),
    .expire (w_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FILL;
      r_asm   <= '0;
      r_hold  <= '0;
      r_valid <= 1'b0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      r_drop <= 1'b0;
      // A transfer empties hold unless a later branch reloads it in the same edge.
      if (r_valid && blk.block_ready) r_valid <= 1'b0;

      case (r_state)
        FILL: begin
          if (rx_valid) begin
            if (rx_err) begin
              r_asm  <= '0;
              r_cnt  <= '0;
              r_drop <= 1'b1;
            end else if (w_last) begin
              if (w_hold_free) begin
                r_hold  <= w_shifted;
                r_valid <= 1'b1;
                r_asm   <= '0;
                r_cnt   <= '0;
              end else begin
                r_asm   <= w_shifted;
                r_cnt   <= CW'(BLOCK_BYTES);
                r_state <= WAIT;
              end
            end else begin
              r_asm <= w_shifted;
              r_cnt <= r_cnt + 1'b1;
            end
          end else if (w_expire) begin
`ifdef UART_BLOCK_PAD_EN
            if (w_hold_free) begin
              r_hold  <= w_padded;
              r_valid <= 1'b1;
              r_asm   <= '0;
              r_cnt   <= '0;
            end else begin
              r_asm   <= w_padded;
              r_cnt   <= CW'(BLOCK_BYTES);
              r_state <= WAIT;
            end
`else
            r_asm  <= '0;
            r_cnt  <= '0;
            r_drop <= 1'b1;
`endif
          end
        end
        WAIT: begin
          if (rx_valid && !rx_err) r_ovf <= 1'b1;
          if (r_valid && blk.block_ready) begin
            r_hold  <= r_asm;
            r_valid <= 1'b1;
            r_asm   <= '0;
            r_cnt   <= '0;
            r_state <= FILL;
          end
        end
        default: r_state <= FILL;
      endcase
    end
  end

  assign blk.block_data  = r_hold;
  assign blk.block_valid = r_valid;
  assign byte_cnt        = r_cnt;
  assign overflow        = r_ovf;
  assign drop_pulse      = r_drop;
endmodule

// File: tb/tb_uart_block_packer.sv
// Scoreboard bench for uart_block_packer (16-byte blocks, 1000-cycle timeout).
module tb_uart_block_packer;
  import aes_uart_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_err;
  logic [4:0] byte_cnt;
  logic       overflow;
  logic       drop_pulse;

  int     n_total = 0;
  int     n_bad   = 0;
  int     n_drops = 0;
  block_t exp_q[$];
  logic   stall_prev = 1'b0;
  block_t data_prev;

  always #5 clk = ~clk;

  uart_block_packer_if #(.W(BLOCK_W)) bif ();

  uart_block_packer #(
    .BLOCK_BYTES    (16),
    .TIMEOUT_CYCLES (1000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_err     (rx_err),
    .blk        (bif),
    .byte_cnt   (byte_cnt),
    .overflow   (overflow),
    .drop_pulse (drop_pulse)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on each accepted block and checks hold stability.
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev && bif.block_valid) check("hold_stable", bif.block_data, data_prev);
      if (bif.block_valid && bif.block_ready) begin
        if (exp_q.size() == 0) begin
          n_total++;
          n_bad++;
          $display("FAIL unexpected_block: got %h expected none", bif.block_data);
        end else begin
          check("block_data", bif.block_data, exp_q.pop_front());
        end
      end
      if (drop_pulse) n_drops++;
      stall_prev = bif.block_valid && !bif.block_ready;
      data_prev  = bif.block_data;
    end
  end

  task automatic send(input logic [7:0] b, input logic e);
    rx_data  = b;
    rx_valid = 1'b1;
    rx_err   = e;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_err   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int c = 0; c < 50; c++) begin
      if (exp_q.size() == 0 && !bif.block_valid) break;
      @(posedge clk);
      #1;
    end
    check(name, 128'(exp_q.size()), 128'd0);
    check({name, "_valid"}, 128'(bif.block_valid), 128'd0);
  endtask

  task automatic send_ramp11(input int n);
    for (int i = 0; i < n; i++) send(8'(i * 17), 1'b0);
  endtask

  initial begin
    rx_data = '0; rx_valid = 1'b0; rx_err = 1'b0; bif.block_ready = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    check("rst_valid", 128'(bif.block_valid), 128'd0);
    check("rst_data", bif.block_data, 128'd0);
    check("rst_cnt", 128'(byte_cnt), 128'd0);
    check("rst_ovf", 128'(overflow), 128'd0);
    check("rst_drop", 128'(drop_pulse), 128'd0);
    rst = 1'b0;

    // Test 1: single block, latency exactly one clock.
    bif.block_ready = 1'b1;
    send_ramp11(15);
    check("t1_cnt15", 128'(byte_cnt), 128'd15);
    check("t1_no_early", 128'(bif.block_valid), 128'd0);
    exp_q.push_back(128'h00112233445566778899aabbccddeeff);
    send(8'hff, 1'b0);
    check("t1_latency", 128'(bif.block_valid), 128'd1);
    check("t1_data", bif.block_data, 128'h00112233445566778899aabbccddeeff);
    check("t1_cnt0", 128'(byte_cnt), 128'd0);
    drain("t1_drain");

    // Test 2: two back-to-back blocks plus one trailing byte.
    exp_q.push_back(128'h00112233445566778899aabbccddeeff);
    exp_q.push_back(128'h00112233445566778899aabbccddee01);
    send_ramp11(16);
    send_ramp11(15);
    send(8'h01, 1'b0);
    send(8'h5a, 1'b0);
    drain("t2_drain");
    check("t2_cnt1", 128'(byte_cnt), 128'd1);
    check("t2_ovf", 128'(overflow), 128'd0);

    // Test 3: backpressure, WAIT freeze and overflow.
    do_reset();
    bif.block_ready = 1'b0;
    exp_q.push_back(128'h000102030405060708090a0b0c0d0e0f);
    exp_q.push_back(128'h101112131415161718191a1b1c1d1e1f);
    for (int i = 0; i < 48; i++) send(8'(i), 1'b0);
    check("t3_cnt_sat", 128'(byte_cnt), 128'd16);
    check("t3_ovf", 128'(overflow), 128'd1);
    check("t3_valid", 128'(bif.block_valid), 128'd1);
    check("t3_hold", bif.block_data, 128'h000102030405060708090a0b0c0d0e0f);
    repeat (3) @(posedge clk);
    #1;
    bif.block_ready = 1'b1;
    drain("t3_drain");
    check("t3_cnt0", 128'(byte_cnt), 128'd0);
    check("t3_ovf_sticky", 128'(overflow), 128'd1);

    // Test 4: inter-byte timeout after 5 bytes.
    do_reset();
    send_ramp11(5);
    repeat (999) @(posedge clk);
    #1;
    check("t4_pre_drop", 128'(drop_pulse), 128'd0);
    check("t4_pre_cnt", 128'(byte_cnt), 128'd5);
`ifdef UART_BLOCK_PAD_EN
    exp_q.push_back(128'h00112233440000000000000000000000);
`endif
    @(posedge clk);
    #1;
    check("t4_cnt0", 128'(byte_cnt), 128'd0);
`ifdef UART_BLOCK_PAD_EN
    check("t4_drop", 128'(drop_pulse), 128'd0);
    check("t4_pad_valid", 128'(bif.block_valid), 128'd1);
`else
    check("t4_drop", 128'(drop_pulse), 128'd1);
    check("t4_no_block", 128'(bif.block_valid), 128'd0);
`endif
    @(posedge clk);
    #1;
    check("t4_drop_once", 128'(drop_pulse), 128'd0);
    drain("t4_drain");

    // Test 5: receiver error discards partial block, then clean realignment.
    for (int i = 0; i < 7; i++) send(8'(8'ha0 + i), 1'b0);
    send(8'h77, 1'b1);
    check("t5_drop", 128'(drop_pulse), 128'd1);
    check("t5_cnt0", 128'(byte_cnt), 128'd0);
    exp_q.push_back(128'h00112233445566778899aabbccddeeff);
    send_ramp11(16);
    drain("t5_drain");

    // Test 6: reset mid-block leaves no residue.
    for (int i = 0; i < 10; i++) send(8'(8'hc0 + i), 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("t6_rst_cnt", 128'(byte_cnt), 128'd0);
    check("t6_rst_valid", 128'(bif.block_valid), 128'd0);
    check("t6_rst_ovf", 128'(overflow), 128'd0);
    check("t6_rst_drop", 128'(drop_pulse), 128'd0);
    rst = 1'b0;
    exp_q.push_back(128'h00112233445566778899aabbccddeeff);
    send_ramp11(16);
    drain("t6_drain");

`ifdef UART_BLOCK_PAD_EN
    check("drop_count", 128'(n_drops), 128'd1);
`else
    check("drop_count", 128'(n_drops), 128'd2);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
